// File: rtl/wbi_pkg.sv
// Shared types and widths for the Wishbone interconnect master/slave nodes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wbi_pkg;

  // Transaction-ID width carried on both command and response streams
  localparam int TID_W = 4;

  // Default bus geometry, used for the packed stream widths shared with the slave node
  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  localparam int BW_DEF = 4;
  localparam int BL_DEF = 10;

  // Command stream: adr + we + dat + sel + tid + bl
  localparam int CFW = AW_DEF + 1 + DW_DEF + BW_DEF + TID_W + BL_DEF;
  // Response stream: dat + lack + err + tid
  localparam int RFW = DW_DEF + 1 + 1 + TID_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_CMD  = 3'd1,
    ST_WR_ACK  = 3'd2,
    ST_RD_CMD  = 3'd3,
    ST_RD_DATA = 3'd4
  } wbi_state_e;

  // Transaction IDs wrap 15 -> 0
  function automatic logic [TID_W-1:0] tid_next(input logic [TID_W-1:0] t);
    return t + TID_W'(1);
  endfunction

endpackage

// File: rtl/wbi_master_node.sv
// Wishbone master port -> interconnect command/response streams, with tid generation and read timeout.
// Latency: stb -> cmd_val 1 cycle; write ack 1 cycle after cmd accept; read ack combinational on matching response.
// Backpressure: cmd held until wrdy; rrdy follows master bry in reads, stale/mismatched responses always drained.
module wbi_master_node
  import wbi_pkg::*;
#(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int BW   = 4,
  parameter int BL   = 10,
  parameter int TO_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             wbm_cyc_i,
  input  logic             wbm_stb_i,
  input  logic [AW-1:0]    wbm_adr_i,
  input  logic             wbm_we_i,
  input  logic [DW-1:0]    wbm_dat_i,
  input  logic [BW-1:0]    wbm_sel_i,
  input  logic [BL-1:0]    wbm_bl_i,
  input  logic             wbm_bry_i,
  output logic [DW-1:0]    wbm_dat_o,
  output logic             wbm_ack_o,
  output logic             wbm_lack_o,
  output logic             wbm_err_o,
  input  logic             wbd_cmd_wrdy_i,
  output logic             wbd_cmd_val_o,
  output logic [AW-1:0]    wbd_cmd_adr_o,
  output logic             wbd_cmd_we_o,
  output logic [DW-1:0]    wbd_cmd_dat_o,
  output logic [BW-1:0]    wbd_cmd_sel_o,
  output logic [TID_W-1:0] wbd_cmd_tid_o,
  output logic [BL-1:0]    wbd_cmd_bl_o,
  output logic             wbd_res_rrdy_o,
  input  logic             wbd_res_rval_i,
  input  logic [DW-1:0]    wbd_res_dat_i,
  input  logic             wbd_res_lack_i,
  input  logic             wbd_res_err_i,
  input  logic [TID_W-1:0] wbd_res_tid_i
);

  wbi_state_e       state_q;
  logic [AW-1:0]    adr_q;
  logic             we_q;
  logic [DW-1:0]    dat_q;
  logic [BW-1:0]    sel_q;
  logic [BL-1:0]    bl_q;
  logic [BL-1:0]    beat_cnt_q;
  logic [TID_W-1:0] tid_q;
  logic [TO_W-1:0]  to_cnt_q;
  // Low for the first cycle after reset so every output reads 0 there, including rrdy
  logic             armed_q;

  logic             req;
  logic [BL-1:0]    bl_eff;
  logic             in_rd;
  logic             tid_match;
  logic             beat_acc;
  logic             to_fire;

  assign req       = wbm_cyc_i & wbm_stb_i;
  assign bl_eff    = (wbm_bl_i == '0) ? BL'(1) : wbm_bl_i;
  assign in_rd     = (state_q == ST_RD_DATA);
  assign tid_match = (wbd_res_tid_i == tid_q);
  // A master that abandoned the cycle no longer drives bry, so drain its beats regardless
  assign beat_acc  = in_rd & wbd_res_rval_i & tid_match & (wbm_bry_i | ~wbm_cyc_i);
  // A beat landing in the terminal-count cycle wins over the timeout
  assign to_fire   = in_rd & ~beat_acc & (&to_cnt_q);

  // FSM plus command register, beat counter, transaction ID and read-timeout counter
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      adr_q      <= '0;
      we_q       <= 1'b0;
      dat_q      <= '0;
      sel_q      <= '0;
      bl_q       <= '0;
      beat_cnt_q <= '0;
      tid_q      <= '0;
      to_cnt_q   <= '0;
      armed_q    <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (req) begin
            adr_q      <= wbm_adr_i;
            we_q       <= wbm_we_i;
            dat_q      <= wbm_dat_i;
            sel_q      <= wbm_sel_i;
            bl_q       <= bl_eff;
            beat_cnt_q <= bl_eff;
            state_q    <= wbm_we_i ? ST_WR_CMD : ST_RD_CMD;
          end
        end
        ST_WR_CMD: begin
          if (wbd_cmd_wrdy_i) begin
            beat_cnt_q <= beat_cnt_q - BL'(1);
            state_q    <= ST_WR_ACK;
          end
        end
        ST_WR_ACK: begin
          if (beat_cnt_q == '0) begin
            tid_q   <= tid_next(tid_q);
            state_q <= ST_IDLE;
          end else begin
            dat_q   <= wbm_dat_i;
            sel_q   <= wbm_sel_i;
            adr_q   <= adr_q + AW'(BW);
            state_q <= ST_WR_CMD;
          end
        end
        ST_RD_CMD: begin
          if (wbd_cmd_wrdy_i) begin
            to_cnt_q <= '0;
            state_q  <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (beat_acc) begin
            to_cnt_q <= '0;
            if (wbd_res_lack_i) begin
              tid_q   <= tid_next(tid_q);
              state_q <= ST_IDLE;
            end
          end else if (to_fire) begin
            // Retiring the tid makes any late beats of this read mismatch and get flushed
            tid_q   <= tid_next(tid_q);
            state_q <= ST_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Stream and master-port outputs decoded from the state; read acks pass straight through
  always_comb begin
    wbd_cmd_val_o  = 1'b0;
    wbd_cmd_adr_o  = '0;
    wbd_cmd_we_o   = 1'b0;
    wbd_cmd_dat_o  = '0;
    wbd_cmd_sel_o  = '0;
    wbd_cmd_tid_o  = '0;
    wbd_cmd_bl_o   = '0;
    wbd_res_rrdy_o = 1'b0;
    wbm_ack_o      = 1'b0;
    wbm_lack_o     = 1'b0;
    wbm_err_o      = 1'b0;
    wbm_dat_o      = '0;
    unique case (state_q)
      ST_IDLE: begin
        wbd_res_rrdy_o = armed_q;
      end
      ST_WR_CMD, ST_RD_CMD: begin
        wbd_cmd_val_o = 1'b1;
        wbd_cmd_adr_o = adr_q;
        wbd_cmd_we_o  = we_q;
        wbd_cmd_dat_o = dat_q;
        wbd_cmd_sel_o = sel_q;
        wbd_cmd_tid_o = tid_q;
        wbd_cmd_bl_o  = bl_q;
      end
      ST_WR_ACK: begin
        wbm_ack_o  = wbm_cyc_i;
        wbm_lack_o = wbm_cyc_i & (beat_cnt_q == '0);
      end
      ST_RD_DATA: begin
        wbd_res_rrdy_o = wbm_bry_i | ~wbm_cyc_i | (wbd_res_rval_i & ~tid_match);
        if (beat_acc & wbm_cyc_i) begin
          wbm_ack_o  = 1'b1;
          wbm_dat_o  = wbd_res_dat_i;
          wbm_err_o  = wbd_res_err_i;
          wbm_lack_o = wbd_res_lack_i;
        end else if (to_fire & wbm_cyc_i) begin
          wbm_ack_o  = 1'b1;
          wbm_lack_o = 1'b1;
          wbm_err_o  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wbi_master_node.sv
// Directed bench for wbi_master_node: writes, bursts, stale flush, timeout, reset, abandoned cycle.
// Latency: inputs driven on negedge, outputs sampled 1 time unit later.
// Backpressure: wrdy stall and bry toggling exercised explicitly.
module tb_wbi_master_node;
  localparam int AW = 32, DW = 32, BW = 4, BL = 10, TO_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_bry_i;
  logic [AW-1:0] wbm_adr_i;
  logic [DW-1:0] wbm_dat_i;
  logic [BW-1:0] wbm_sel_i;
  logic [BL-1:0] wbm_bl_i;
  logic [DW-1:0] wbm_dat_o;
  logic wbm_ack_o, wbm_lack_o, wbm_err_o;
  logic wbd_cmd_wrdy_i, wbd_cmd_val_o, wbd_cmd_we_o;
  logic [AW-1:0] wbd_cmd_adr_o;
  logic [DW-1:0] wbd_cmd_dat_o;
  logic [BW-1:0] wbd_cmd_sel_o;
  logic [3:0] wbd_cmd_tid_o;
  logic [BL-1:0] wbd_cmd_bl_o;
  logic wbd_res_rrdy_o, wbd_res_rval_i, wbd_res_lack_i, wbd_res_err_i;
  logic [DW-1:0] wbd_res_dat_i;
  logic [3:0] wbd_res_tid_i;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wbi_master_node #(.AW(AW), .DW(DW), .BW(BW), .BL(BL), .TO_W(TO_W)) dut (
    .clk_i(clk), .rst_n(rst_n),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_adr_i(wbm_adr_i), .wbm_we_i(wbm_we_i),
    .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i), .wbm_bl_i(wbm_bl_i), .wbm_bry_i(wbm_bry_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_lack_o(wbm_lack_o), .wbm_err_o(wbm_err_o),
    .wbd_cmd_wrdy_i(wbd_cmd_wrdy_i), .wbd_cmd_val_o(wbd_cmd_val_o), .wbd_cmd_adr_o(wbd_cmd_adr_o),
    .wbd_cmd_we_o(wbd_cmd_we_o), .wbd_cmd_dat_o(wbd_cmd_dat_o), .wbd_cmd_sel_o(wbd_cmd_sel_o),
    .wbd_cmd_tid_o(wbd_cmd_tid_o), .wbd_cmd_bl_o(wbd_cmd_bl_o),
    .wbd_res_rrdy_o(wbd_res_rrdy_o), .wbd_res_rval_i(wbd_res_rval_i), .wbd_res_dat_i(wbd_res_dat_i),
    .wbd_res_lack_i(wbd_res_lack_i), .wbd_res_err_i(wbd_res_err_i), .wbd_res_tid_i(wbd_res_tid_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [AW-1:0] adr, input logic we, input logic [DW-1:0] dat,
                     input logic [BL-1:0] bl);
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    wbm_adr_i = adr; wbm_we_i = we; wbm_dat_i = dat; wbm_sel_i = 4'hF; wbm_bl_i = bl;
  endtask

  task automatic drop();
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
  endtask

  task automatic chk_cmd(input string tag, input logic [AW-1:0] adr, input logic we,
                         input logic [DW-1:0] dat, input logic [3:0] tid, input logic [BL-1:0] bl);
    chk({tag, "_val"}, 64'(wbd_cmd_val_o), 64'd1);
    chk({tag, "_adr"}, 64'(wbd_cmd_adr_o), 64'(adr));
    chk({tag, "_we"},  64'(wbd_cmd_we_o), 64'(we));
    chk({tag, "_dat"}, 64'(wbd_cmd_dat_o), 64'(dat));
    chk({tag, "_tid"}, 64'(wbd_cmd_tid_o), 64'(tid));
    chk({tag, "_bl"},  64'(wbd_cmd_bl_o), 64'(bl));
    chk({tag, "_noack"}, 64'(wbm_ack_o), 64'd0);
  endtask

  // {ack, lack, err, dat}
  task automatic chk_ack(input string tag, input logic ack, input logic lack, input logic err,
                         input logic [DW-1:0] dat);
    chk(tag, {29'd0, wbm_ack_o, wbm_lack_o, wbm_err_o, wbm_dat_o}, {29'd0, ack, lack, err, dat});
  endtask

  task automatic resp(input logic vld, input logic [3:0] tid, input logic [DW-1:0] dat,
                      input logic lack, input logic err);
    wbd_res_rval_i = vld; wbd_res_tid_i = tid; wbd_res_dat_i = dat;
    wbd_res_lack_i = lack; wbd_res_err_i = err;
  endtask

  initial begin
    int bad_quiet;
    rst_n = 1'b0; drop(); wbm_adr_i = '0; wbm_we_i = 1'b0; wbm_dat_i = '0; wbm_sel_i = '0;
    wbm_bl_i = '0; wbm_bry_i = 1'b1; wbd_cmd_wrdy_i = 1'b1; resp(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cmd", {wbd_cmd_val_o, wbd_cmd_we_o, wbd_cmd_adr_o, wbd_cmd_tid_o, wbd_cmd_bl_o}, 64'd0);
    chk("rst_dat", {wbd_cmd_dat_o, wbd_cmd_sel_o}, 64'd0);
    chk("rst_res", {wbd_res_rrdy_o, wbm_ack_o, wbm_lack_o, wbm_err_o, wbm_dat_o}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Single write, bl=0 treated as 1
    @(negedge clk); req(32'h100, 1'b1, 32'hA5A5_0001, 10'd0);
    @(negedge clk); #1; chk_cmd("w1", 32'h100, 1'b1, 32'hA5A5_0001, 4'd0, 10'd1);
    @(negedge clk); #1; chk_ack("w1_ack", 1'b1, 1'b1, 1'b0, 32'd0); drop();
    @(negedge clk); #1; chk_ack("w1_idle", 1'b0, 1'b0, 1'b0, 32'd0);
    chk("w1_idle_rrdy", 64'(wbd_res_rrdy_o), 64'd1);

    // Burst write bl=3 with a 4-cycle wrdy stall on beat 2
    @(negedge clk); req(32'h200, 1'b1, 32'hD000_0000, 10'd3);
    @(negedge clk); #1; chk_cmd("bw0", 32'h200, 1'b1, 32'hD000_0000, 4'd1, 10'd3);
    @(negedge clk); #1; chk_ack("bw0_ack", 1'b1, 1'b0, 1'b0, 32'd0); wbm_dat_i = 32'hD000_0001;
    @(negedge clk); wbd_cmd_wrdy_i = 1'b0; #1;
    chk_cmd("bw1", 32'h204, 1'b1, 32'hD000_0001, 4'd1, 10'd3);
    repeat (3) begin
      @(negedge clk); #1; chk_cmd("bw1_stall", 32'h204, 1'b1, 32'hD000_0001, 4'd1, 10'd3);
    end
    @(negedge clk); wbd_cmd_wrdy_i = 1'b1; #1;
    chk_cmd("bw1_go", 32'h204, 1'b1, 32'hD000_0001, 4'd1, 10'd3);
    @(negedge clk); #1; chk_ack("bw1_ack", 1'b1, 1'b0, 1'b0, 32'd0); wbm_dat_i = 32'hD000_0002;
    @(negedge clk); #1; chk_cmd("bw2", 32'h208, 1'b1, 32'hD000_0002, 4'd1, 10'd3);
    @(negedge clk); #1; chk_ack("bw2_ack", 1'b1, 1'b1, 1'b0, 32'd0); drop();
    @(negedge clk); #1; chk_ack("bw_idle", 1'b0, 1'b0, 1'b0, 32'd0);

    // Burst read bl=4, bry toggling 0/1 per beat
    @(negedge clk); req(32'h300, 1'b0, 32'd0, 10'd4);
    @(negedge clk); #1; chk_cmd("br", 32'h300, 1'b0, 32'd0, 4'd2, 10'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); wbm_bry_i = 1'b0; resp(1'b1, 4'd2, 32'(8'h11 * (i + 1)), i == 3, 1'b0); #1;
      chk("br_rrdy_lo", 64'(wbd_res_rrdy_o), 64'd0);
      chk_ack("br_hold", 1'b0, 1'b0, 1'b0, 32'd0);
      @(negedge clk); wbm_bry_i = 1'b1; #1;
      chk("br_rrdy_hi", 64'(wbd_res_rrdy_o), 64'd1);
      chk_ack("br_beat", 1'b1, i == 3, 1'b0, 32'(8'h11 * (i + 1)));
    end
    @(negedge clk); resp(1'b0, 4'd0, 32'd0, 1'b0, 1'b0); drop(); #1;
    chk_ack("br_idle", 1'b0, 1'b0, 1'b0, 32'd0);

    // Read with a stale response ahead of the real beats; stale beat drained even with bry low
    @(negedge clk); req(32'h400, 1'b0, 32'd0, 10'd2);
    @(negedge clk); #1; chk_cmd("st", 32'h400, 1'b0, 32'd0, 4'd3, 10'd2);
    @(negedge clk); wbm_bry_i = 1'b0; resp(1'b1, 4'd2, 32'hDEAD, 1'b1, 1'b1); #1;
    chk("st_stale_rrdy", 64'(wbd_res_rrdy_o), 64'd1);
    chk_ack("st_stale", 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk); wbm_bry_i = 1'b1; resp(1'b1, 4'd3, 32'h55, 1'b0, 1'b1); #1;
    chk_ack("st_b0", 1'b1, 1'b0, 1'b1, 32'h55);
    @(negedge clk); resp(1'b1, 4'd3, 32'h66, 1'b1, 1'b0); #1;
    chk_ack("st_b1", 1'b1, 1'b1, 1'b0, 32'h66);
    @(negedge clk); resp(1'b0, 4'd0, 32'd0, 1'b0, 1'b0); drop(); #1;
    chk_ack("st_idle", 1'b0, 1'b0, 1'b0, 32'd0);

    // Read timeout: 255 silent cycles, then one ack=lack=err cycle
    @(negedge clk); req(32'h500, 1'b0, 32'd0, 10'd1);
    @(negedge clk); #1; chk_cmd("to", 32'h500, 1'b0, 32'd0, 4'd4, 10'd1);
    bad_quiet = 0;
    for (int k = 0; k < 255; k++) begin
      @(negedge clk); #1;
      if (wbm_ack_o !== 1'b0) bad_quiet++;
    end
    chk("to_quiet", 64'(bad_quiet), 64'd0);
    @(negedge clk); #1; chk_ack("to_fire", 1'b1, 1'b1, 1'b1, 32'd0); drop();
    @(negedge clk); #1; chk_ack("to_after", 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (40) @(negedge clk);
    resp(1'b1, 4'd4, 32'hBAD, 1'b1, 1'b0); #1;
    chk("to_late_rrdy", 64'(wbd_res_rrdy_o), 64'd1);
    chk_ack("to_late", 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk); resp(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);

    // Reset during beat 2 of a 4-beat read
    @(negedge clk); req(32'h600, 1'b0, 32'd0, 10'd4);
    @(negedge clk); #1; chk_cmd("rr", 32'h600, 1'b0, 32'd0, 4'd5, 10'd4);
    @(negedge clk); resp(1'b1, 4'd5, 32'h77, 1'b0, 1'b0); #1;
    chk_ack("rr_b0", 1'b1, 1'b0, 1'b0, 32'h77);
    @(negedge clk); resp(1'b1, 4'd5, 32'h88, 1'b0, 1'b0); rst_n = 1'b0; drop();
    @(negedge clk); #1;
    chk("rr_rst_cmd", {wbd_cmd_val_o, wbd_cmd_we_o, wbd_cmd_adr_o, wbd_cmd_tid_o, wbd_cmd_bl_o}, 64'd0);
    chk("rr_rst_res", {wbd_res_rrdy_o, wbm_ack_o, wbm_lack_o, wbm_err_o, wbm_dat_o}, 64'd0);
    rst_n = 1'b1; resp(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk); req(32'h700, 1'b1, 32'h1234_5678, 10'd1);
    @(negedge clk); #1; chk_cmd("pr", 32'h700, 1'b1, 32'h1234_5678, 4'd0, 10'd1);
    @(negedge clk); #1; chk_ack("pr_ack", 1'b1, 1'b1, 1'b0, 32'd0); drop();

    // Master abandons a 2-beat write: transaction completes silently, tid still advances
    @(negedge clk); req(32'h800, 1'b1, 32'hCAFE_0000, 10'd2);
    @(negedge clk); #1; chk_cmd("ab0", 32'h800, 1'b1, 32'hCAFE_0000, 4'd1, 10'd2); drop();
    @(negedge clk); #1; chk_ack("ab0_sup", 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk); #1; chk("ab1_adr", 64'(wbd_cmd_adr_o), 64'h804);
    @(negedge clk); #1; chk_ack("ab1_sup", 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk); req(32'h900, 1'b1, 32'h9, 10'd1);
    @(negedge clk); #1; chk_cmd("ab_next", 32'h900, 1'b1, 32'h9, 4'd2, 10'd1);
    @(negedge clk); #1; chk_ack("ab_next_ack", 1'b1, 1'b1, 1'b0, 32'd0); drop();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
